// File: rtl/text_console_writer.sv
// Character-cell text buffer between the CPU byte stream and the VGA text unit.
// Define CURSOR_BLINK_EN to overlay a blinking '_' at the cursor cell on VGA reads.
module text_console_writer #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 60,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
`ifdef CURSOR_BLINK_EN
  ,
  parameter int unsigned BLINK_DIV  = 25_000_000
`endif
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [6:0] AddressRd,
  input  logic [6:0] fila,
  output logic [7:0] ScreenChar,
  output logic [6:0] cursor_col,
  output logic [5:0] cursor_row,
  output logic       busy
);
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 6;
  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned ADDR_W = $clog2(CELLS);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_SCROLL_CLR} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [COL_W-1:0]  clr_col_q;
  logic [ROW_W-1:0]  top_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic              ready_q;
  logic              busy_q;
  logic [7:0]        screen_q;
  logic [7:0]        mem [CELLS];

  logic [ROW_W:0]    wr_sum;
  logic [ROW_W-1:0]  wr_prow;
  logic [ADDR_W-1:0] cur_idx;
  logic [ADDR_W-1:0] bs_idx;
  logic [ROW_W-1:0]  top_inc;
  logic              accept;
  logic              is_ctrl;
  logic              advance;
  logic [7:0]        rd_sum;
  logic [6:0]        rd_prow;
  logic              rd_in;
  logic [ADDR_W-1:0] rd_idx;

  // Logical-to-physical mapping through the rotating top-row pointer.
  always_comb begin
    wr_sum  = {1'b0, row_q} + {1'b0, top_q};
    wr_prow = (wr_sum >= (ROW_W+1)'(ROWS)) ? ROW_W'(wr_sum - (ROW_W+1)'(ROWS))
                                           : ROW_W'(wr_sum);
    cur_idx = ADDR_W'(wr_prow) * COLS_A + ADDR_W'(col_q);
    bs_idx  = cur_idx - ADDR_W'(1);
    top_inc = (top_q == ROW_W'(ROWS - 1)) ? '0 : top_q + ROW_W'(1);
    accept  = char_valid && ready_q && (state_q == ST_IDLE);
    is_ctrl = (char_data == CH_BS) || (char_data == CH_LF) ||
              (char_data == CH_FF) || (char_data == CH_CR);
    advance = accept && ((char_data == CH_LF) ||
                         (!is_ctrl && (col_q == COL_W'(COLS - 1))));

    rd_sum  = {1'b0, fila} + {2'b00, top_q};
    rd_prow = (rd_sum >= 8'(ROWS)) ? 7'(rd_sum - 8'(ROWS)) : 7'(rd_sum);
    rd_in   = ({1'b0, AddressRd} < 8'(COLS)) && ({1'b0, fila} < 8'(ROWS));
    rd_idx  = rd_in ? (ADDR_W'(rd_prow) * COLS_A + ADDR_W'(AddressRd)) : '0;
  end

  // Control FSM; owns the single write port of the screen RAM.
  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      clr_col_q  <= '0;
      top_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          mem[clr_addr_q] <= CLEAR_CHAR;
          if (clr_addr_q == ADDR_W'(CELLS - 1)) begin
            state_q <= ST_IDLE;
            top_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + ADDR_W'(1);
          end
        end
        ST_SCROLL_CLR: begin
          mem[clr_addr_q] <= CLEAR_CHAR;
          clr_addr_q      <= clr_addr_q + ADDR_W'(1);
          clr_col_q       <= clr_col_q + COL_W'(1);
          if (clr_col_q == COL_W'(COLS - 1)) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            case (char_data)
              CH_LF: col_q <= '0;
              CH_CR: col_q <= '0;
              CH_BS: begin
                if (col_q != '0) begin
                  col_q       <= col_q - COL_W'(1);
                  mem[bs_idx] <= CLEAR_CHAR;
                end
              end
              CH_FF: begin
                state_q    <= ST_CLEAR;
                clr_addr_q <= '0;
                top_q      <= '0;
                row_q      <= '0;
                col_q      <= '0;
                ready_q    <= 1'b0;
                busy_q     <= 1'b1;
              end
              default: begin
                mem[cur_idx] <= char_data;
                col_q <= (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
              end
            endcase
          end
          // Bottom-row advance rotates top; the old top row becomes the new bottom.
          if (advance) begin
            if (row_q != ROW_W'(ROWS - 1)) begin
              row_q <= row_q + ROW_W'(1);
            end else begin
              top_q      <= top_inc;
              clr_addr_q <= ADDR_W'(top_q) * COLS_A;
              clr_col_q  <= '0;
              state_q    <= ST_SCROLL_CLR;
              ready_q    <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_CLEAR;
          clr_addr_q <= '0;
          ready_q    <= 1'b0;
          busy_q     <= 1'b1;
        end
      endcase
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [7:0]  CURSOR_GLYPH = 8'h5F;

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_on_q;
  logic               cursor_hit;

  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blink_on_q  <= ~blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
    end
  end

  assign cursor_hit = blink_on_q && (fila == {1'b0, row_q}) && (AddressRd == col_q);
`endif

  // VGA read port: one-cycle registered read, blanking outside the visible grid.
  always_ff @(posedge clk_50MHz) begin
    if (!reset || !rd_in) begin
      screen_q <= CLEAR_CHAR;
`ifdef CURSOR_BLINK_EN
    end else if (cursor_hit) begin
      screen_q <= CURSOR_GLYPH;
`endif
    end else begin
      screen_q <= mem[rd_idx];
    end
  end

  assign char_ready = ready_q;
  assign busy       = busy_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign ScreenChar = screen_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer against a logical-screen reference model.
module tb_text_console_writer;
  localparam int COLS    = 80;
  localparam int ROWS    = 60;
  localparam int CELLS   = COLS * ROWS;
  localparam int TIMEOUT = 6000;
  localparam logic [7:0] BLANK = 8'h20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [6:0] addr_rd = 7'd0;
  logic [6:0] fila = 7'd0;
  logic [7:0] screen_char;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Logical screen: row 0 is the top visible row; scrolling moves rows up.
  logic [7:0] scr [ROWS][COLS];
  int m_col = 0;
  int m_row = 0;

  text_console_writer dut (
    .clk_50MHz (clk),
    .reset     (rst_n),
    .char_data (char_data),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .AddressRd (addr_rd),
    .fila      (fila),
    .ScreenChar(screen_char),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  initial begin
    #(90000 * 20);
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1);
  end

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = BLANK;
    m_col = 0;
    m_row = 0;
  endtask

  task automatic model_advance();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = BLANK;
    end
  endtask

  task automatic model_accept(input logic [7:0] b);
    case (b)
      8'h0A: begin m_col = 0; model_advance(); end
      8'h0D: m_col = 0;
      8'h08: if (m_col > 0) begin m_col--; scr[m_row][m_col] = BLANK; end
      8'h0C: model_clear();
      default: begin
        scr[m_row][m_col] = b;
        if (m_col < COLS - 1) m_col++;
        else begin m_col = 0; model_advance(); end
      end
    endcase
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] b;
    r = $urandom_range(0, 19);
    if (r == 0) return 8'h0A;
    if (r == 1) return 8'h0D;
    if (r == 2) return 8'h08;
    do b = 8'($urandom); while (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D);
    return b;
  endfunction

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, output int stall);
    stall = 0;
    char_data  = b;
    char_valid = 1'b1;
    while (!char_ready && stall < TIMEOUT) begin
      @(negedge clk);
      stall++;
    end
    if (!char_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: char_ready=%0b after %0d cycles, required 1", char_ready, stall);
      char_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(b);
      @(negedge clk);
      char_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(output int cycles, output int busy_bad);
    cycles = 0;
    busy_bad = 0;
    while (!char_ready && cycles < TIMEOUT) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic read_cell(input int r, input int c, output logic [7:0] v);
    fila    = 7'(r);
    addr_rd = 7'(c);
    @(negedge clk);
    v = screen_char;
  endtask

  // Pipelined sweep of every visible cell against the model.
  task automatic scan_screen(output int bad, output int fr, output int fc,
                             output logic [7:0] got, output logic [7:0] exp);
    int pr, pc;
    bad = 0; fr = -1; fc = -1; got = 8'h00; exp = 8'h00;
    for (int k = 0; k <= CELLS; k++) begin
      if (k > 0) begin
        pr = (k - 1) / COLS;
        pc = (k - 1) % COLS;
        if (screen_char !== scr[pr][pc]) begin
          if (bad == 0) begin fr = pr; fc = pc; got = screen_char; exp = scr[pr][pc]; end
          bad++;
        end
      end
      if (k < CELLS) begin
        fila    = 7'(k / COLS);
        addr_rd = 7'(k % COLS);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cycles, busy_bad, bad, fr, fc;
    logic [7:0] got, exp;
    rst_n = 1'b0;
    char_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || char_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: busy=%0b ready=%0b, required busy=1 ready=0", busy, char_ready);
    end
    tests_run++;
    if (cursor_col !== 7'd0 || cursor_row !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_cursor: col=%0d row=%0d, required 0,0", cursor_col, cursor_row);
    end
    tests_run++;
    if (screen_char !== BLANK) begin
      tests_failed++;
      $display("FAIL reset_screenchar: got %02h required %02h", screen_char, BLANK);
    end
    rst_n = 1'b1;
    model_clear();
    wait_ready(cycles, busy_bad);
    tests_run++;
    if (cycles !== 4800 || busy_bad !== 0) begin
      tests_failed++;
      $display("FAIL reset_clear_len: %0d cycles (busy low %0d), required 4800 (0)", cycles, busy_bad);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_busy: busy=%0b required 0", busy);
    end
    scan_screen(bad, fr, fc, got, exp);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL reset_screen: %0d cells differ, first (%0d,%0d) got %02h required %02h", bad, fr, fc, got, exp);
    end
  endtask

  task automatic test_basic_write();
    int st;
    logic [7:0] v;
    send_byte(8'h41, st);
    tests_run++;
    if (cursor_col !== 7'(m_col) || cursor_row !== 6'(m_row)) begin
      tests_failed++;
      $display("FAIL basic_cursor: col=%0d row=%0d, required %0d,%0d", cursor_col, cursor_row, m_col, m_row);
    end
    read_cell(0, 0, v);
    tests_run++;
    if (v !== scr[0][0]) begin
      tests_failed++;
      $display("FAIL basic_read: got %02h required %02h", v, scr[0][0]);
    end
  endtask

  task automatic test_wrap_cr_bs();
    int st, stall_sum;
    logic [7:0] v;
    send_byte(8'h0D, st);
    stall_sum = 0;
    for (int i = 0; i < COLS; i++) begin
      send_byte(8'h42, st);
      stall_sum += st;
    end
    tests_run++;
    if (cursor_col !== 7'(m_col) || cursor_row !== 6'(m_row) || stall_sum !== 0) begin
      tests_failed++;
      $display("FAIL wrap_cursor: col=%0d row=%0d stalls=%0d, required %0d,%0d,0", cursor_col, cursor_row, stall_sum, m_col, m_row);
    end
    read_cell(0, COLS - 1, v);
    tests_run++;
    if (v !== scr[0][COLS-1]) begin
      tests_failed++;
      $display("FAIL wrap_last_cell: got %02h required %02h", v, scr[0][COLS-1]);
    end
    for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i), st);
    send_byte(8'h43, st);
    send_byte(8'h08, st);
    tests_run++;
    if (cursor_col !== 7'(m_col) || cursor_row !== 6'(m_row)) begin
      tests_failed++;
      $display("FAIL bs_cursor: col=%0d row=%0d, required %0d,%0d", cursor_col, cursor_row, m_col, m_row);
    end
    read_cell(m_row, m_col, v);
    tests_run++;
    if (v !== scr[m_row][m_col]) begin
      tests_failed++;
      $display("FAIL bs_cell: got %02h required %02h", v, scr[m_row][m_col]);
    end
    send_byte(8'h0D, st);
    send_byte(8'h08, st);
    tests_run++;
    if (cursor_col !== 7'(m_col) || cursor_row !== 6'(m_row)) begin
      tests_failed++;
      $display("FAIL bs_col0: col=%0d row=%0d, required %0d,%0d", cursor_col, cursor_row, m_col, m_row);
    end
  endtask

  task automatic test_random_stream();
    int st, bad, fr, fc;
    logic [7:0] got, exp;
    for (int i = 0; i < 500; i++) begin
      send_byte(rand_byte(), st);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    tests_run++;
    if (cursor_col !== 7'(m_col) || cursor_row !== 6'(m_row)) begin
      tests_failed++;
      $display("FAIL random_cursor: col=%0d row=%0d, required %0d,%0d", cursor_col, cursor_row, m_col, m_row);
    end
    scan_screen(bad, fr, fc, got, exp);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL random_screen: %0d cells differ, first (%0d,%0d) got %02h required %02h", bad, fr, fc, got, exp);
    end
  endtask

  task automatic test_bounds();
    int pr[4] = '{62, 0, 127, 60};
    int pc[4] = '{0, 90, 127, 0};
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      read_cell(pr[i], pc[i], v);
      tests_run++;
      if (v !== BLANK) begin
        tests_failed++;
        $display("FAIL bounds_%0d_%0d: got %02h required %02h", pr[i], pc[i], v, BLANK);
      end
    end
    read_cell(ROWS - 1, COLS - 1, v);
    tests_run++;
    if (v !== scr[ROWS-1][COLS-1]) begin
      tests_failed++;
      $display("FAIL bounds_corner: got %02h required %02h", v, scr[ROWS-1][COLS-1]);
    end
  endtask

  task automatic test_form_feed();
    int st, cycles, busy_bad, bad, fr, fc;
    logic [7:0] got, exp;
    send_byte(8'h0C, st);
    wait_ready(cycles, busy_bad);
    tests_run++;
    if (cycles !== 4800 || busy_bad !== 0) begin
      tests_failed++;
      $display("FAIL ff_clear_len: %0d cycles (busy low %0d), required 4800 (0)", cycles, busy_bad);
    end
    tests_run++;
    if (cursor_col !== 7'd0 || cursor_row !== 6'd0) begin
      tests_failed++;
      $display("FAIL ff_cursor: col=%0d row=%0d, required 0,0", cursor_col, cursor_row);
    end
    scan_screen(bad, fr, fc, got, exp);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL ff_screen: %0d cells differ, first (%0d,%0d) got %02h required %02h", bad, fr, fc, got, exp);
    end
  endtask

  task automatic test_scroll();
    int st, bad, fr, fc, stall_bad;
    logic [7:0] got, exp, v;
    for (int r = 0; r < ROWS; r++) begin
      send_byte(8'h30 + 8'(r), st);
      if (r < ROWS - 1) send_byte(8'h0A, st);
    end
    send_byte(8'h0A, st);
    tests_run++;
    if (busy !== 1'b1 || char_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL scroll_flags: busy=%0b ready=%0b, required 1,0", busy, char_ready);
    end
    send_byte(8'h5A, st);
    tests_run++;
    if (st !== COLS) begin
      tests_failed++;
      $display("FAIL scroll_stall: held byte waited %0d cycles, required %0d", st, COLS);
    end
    read_cell(0, 0, v);
    tests_run++;
    if (v !== scr[0][0]) begin
      tests_failed++;
      $display("FAIL scroll_row0: got %02h required %02h", v, scr[0][0]);
    end
    scan_screen(bad, fr, fc, got, exp);
    tests_run++;
    if (bad !== 0 || cursor_row !== 6'(m_row) || cursor_col !== 7'(m_col)) begin
      tests_failed++;
      $display("FAIL scroll_screen: %0d cells differ (first %0d,%0d got %02h required %02h) cursor %0d,%0d", bad, fr, fc, got, exp, cursor_col, cursor_row);
    end
    stall_bad = 0;
    for (int i = 0; i < ROWS; i++) begin
      send_byte(8'h0A, st);
      send_byte(8'h40 + 8'(i), st);
      if (st != COLS) stall_bad++;
    end
    tests_run++;
    if (stall_bad !== 0) begin
      tests_failed++;
      $display("FAIL scroll_repeat_stall: %0d scrolls with wrong stall, required 0", stall_bad);
    end
    scan_screen(bad, fr, fc, got, exp);
    tests_run++;
    if (bad !== 0 || cursor_row !== 6'(m_row) || cursor_col !== 7'(m_col)) begin
      tests_failed++;
      $display("FAIL scroll_wrap_screen: %0d cells differ (first %0d,%0d got %02h required %02h) cursor %0d,%0d", bad, fr, fc, got, exp, cursor_col, cursor_row);
    end
  endtask

  task automatic test_reset_mid_scroll();
    int st, cycles, busy_bad, bad, fr, fc;
    logic [7:0] got, exp;
    send_byte(8'h0A, st);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_in_scroll: busy=%0b required 1", busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || char_ready !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 6'd0) begin
      tests_failed++;
      $display("FAIL midreset_state: busy=%0b ready=%0b col=%0d row=%0d, required 1,0,0,0", busy, char_ready, cursor_col, cursor_row);
    end
    rst_n = 1'b1;
    model_clear();
    wait_ready(cycles, busy_bad);
    tests_run++;
    if (cycles !== 4800) begin
      tests_failed++;
      $display("FAIL midreset_clear_len: %0d cycles, required 4800", cycles);
    end
    scan_screen(bad, fr, fc, got, exp);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL midreset_screen: %0d cells differ, first (%0d,%0d) got %02h required %02h", bad, fr, fc, got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_wrap_cr_bs();
    test_random_stream();
    test_bounds();
    test_form_feed();
    test_scroll();
    test_reset_mid_scroll();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
